// File: rtl/arb_mux_n_pkg.sv
// arb_mux_n_pkg
// Shared definitions for the arbitrating multiplexer:
//   - DEFAULT_N / DEFAULT_W : default channel count and data width
//   - sel_width()           : grant-index width, clog2(n) with a floor of 1
// Optional feature macro: ARB_MUX_RR_EN (round-robin arbitration).
package arb_mux_n_pkg;

    localparam int unsigned DEFAULT_N = 4;
    localparam int unsigned DEFAULT_W = 32;

    function automatic int unsigned sel_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/arb_mux_n_rr_pick.sv
// rr_pick
// Combinational arbiter: request vector plus priority pointer in,
// one-hot grant plus binary index out.
//   req   : per-channel request
//   ptr   : channel with highest priority (round-robin only)
//   grant : one-hot grant, zero when no request
//   idx   : index of the granted channel, zero when no request
// ARB_MUX_RR_EN defined   : first request at or above ptr, wrapping.
// ARB_MUX_RR_EN undefined : lowest-index request wins, ptr ignored.
module rr_pick
    import arb_mux_n_pkg::*;
#(
    parameter int unsigned N    = DEFAULT_N,
    parameter int unsigned SELW = sel_width(N)
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    output logic [N-1:0]    grant,
    output logic [SELW-1:0] idx
);

`ifdef ARB_MUX_RR_EN
    int unsigned ch;
    logic        found;

    // Walk the channels starting at ptr; the first hit wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        ch    = 0;
        found = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            ch = (int unsigned'(ptr) + k) % N;
            if (!found && req[ch]) begin
                found     = 1'b1;
                grant[ch] = 1'b1;
                idx       = SELW'(ch);
            end
        end
    end
`else
    logic unused_ptr;
    assign unused_ptr = ^ptr;

    always_comb begin
        grant = '0;
        idx   = '0;
        for (int unsigned k = N; k > 0; k--) begin
            if (req[k-1]) begin
                grant     = '0;
                grant[k-1] = 1'b1;
                idx       = SELW'(k - 1);
            end
        end
    end
`endif

endmodule

// File: rtl/arb_mux_n.sv
// arb_mux_n
// N-input, W-bit arbitrating multiplexer with a one-entry registered
// output buffer and valid/ready handshakes on every channel.
//   clk, rst   : clock, synchronous active-high reset
//   in_valid   : per-channel request valid
//   in_data    : flattened channel data, channel i at [i*W +: W]
//   in_ready   : per-channel accept, one-hot or zero
//   out_valid  : output buffer holds a word
//   out_data   : buffered word
//   out_sel    : channel that supplied out_data
//   out_ready  : consumer accepts out_data
// Optional feature macro: ARB_MUX_RR_EN (round-robin; otherwise fixed
// priority with no pointer register).
module arb_mux_n
    import arb_mux_n_pkg::*;
#(
    parameter int unsigned N = DEFAULT_N,
    parameter int unsigned W = DEFAULT_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N-1:0]               in_valid,
    input  logic [N*W-1:0]             in_data,
    output logic [N-1:0]               in_ready,
    output logic                       out_valid,
    output logic [W-1:0]               out_data,
    output logic [sel_width(N)-1:0]    out_sel,
    input  logic                       out_ready
);

    localparam int unsigned SELW = sel_width(N);

    logic            out_valid_q, out_valid_d;
    logic [W-1:0]    out_data_q,  out_data_d;
    logic [SELW-1:0] out_sel_q,   out_sel_d;
    logic [SELW-1:0] ptr;
    logic [N-1:0]    grant;
    logic [SELW-1:0] grant_idx;
    logic            load_en;
    logic            xfer;

    rr_pick #(
        .N    (N),
        .SELW (SELW)
    ) u_pick (
        .req   (in_valid),
        .ptr   (ptr),
        .grant (grant),
        .idx   (grant_idx)
    );

    assign load_en  = !out_valid_q || out_ready;
    assign in_ready = (rst || !load_en) ? '0 : grant;
    assign xfer     = |(in_valid & in_ready);

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        if (load_en) begin
            out_valid_d = xfer;
            if (xfer) begin
                out_data_d = in_data[grant_idx*W +: W];
                out_sel_d  = grant_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
        end
    end

`ifdef ARB_MUX_RR_EN
    logic [SELW-1:0] ptr_q, ptr_d;

    // Priority moves to the channel just after the winner.
    always_comb begin
        ptr_d = ptr_q;
        if (xfer) begin
            if (grant_idx == SELW'(N - 1))
                ptr_d = '0;
            else
                ptr_d = grant_idx + SELW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            ptr_q <= '0;
        else
            ptr_q <= ptr_d;
    end

    assign ptr = ptr_q;
`else
    assign ptr = '0;
`endif

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;

endmodule
